// File: rtl/water_valve_controller_pkg.sv
// Shared types and constants for the water dispenser (entry block and valve controller).
package water_dispenser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPENSE,
    ST_FAULT
  } state_t;

  localparam int AMOUNT_WIDTH_DEFAULT = 32;
  localparam int SWITCH_COUNT         = 10;

endpackage

// File: rtl/water_valve_controller_if.sv
// Request/status bundle between the dispenser front end and the valve controller.
interface water_valve_controller_if #(
  parameter int AMOUNT_WIDTH = 32
);
  logic [AMOUNT_WIDTH-1:0] amount;
  logic                    start;
  logic                    abort;
  logic                    flow_pulse;
  logic                    valve_open;
  logic                    busy;
  logic                    done;
  logic                    aborted;
  logic                    fault;
  logic [AMOUNT_WIDTH-1:0] dispensed;
  logic [AMOUNT_WIDTH-1:0] remaining;

  modport master (
    output amount, start, abort, flow_pulse,
    input  valve_open, busy, done, aborted, fault, dispensed, remaining
  );

  modport slave (
    input  amount, start, abort, flow_pulse,
    output valve_open, busy, done, aborted, fault, dispensed, remaining
  );
endinterface

// File: rtl/water_valve_controller_flow_edge_detector.sv
// Rising-edge detector for the flow meter; FLOW_SYNC_EN adds a 2-flop synchronizer in front.
module flow_edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic flow_pulse,
  output logic flow_edge
);

`ifdef FLOW_SYNC_EN
  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], flow_pulse};
      prev <= sync[1];
    end
  end

  assign flow_edge = sync[1] & ~prev;
`else
  logic prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= flow_pulse;
  end

  assign flow_edge = flow_pulse & ~prev;
`endif

endmodule

// File: rtl/water_valve_controller.sv
// Valve controller: opens on start, counts flow-meter units, closes on completion/abort/timeout.
// Optional FLOW_SYNC_EN synchronizes flow_pulse inside flow_edge_detector.
module water_valve_controller
  import water_dispenser_pkg::*;
#(
  parameter int AMOUNT_WIDTH    = AMOUNT_WIDTH_DEFAULT,
  parameter int PULSES_PER_UNIT = 10,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input logic                     clock,
  input logic                     reset,
  water_valve_controller_if.slave vif
);

  localparam int PW = (PULSES_PER_UNIT > 1) ? $clog2(PULSES_PER_UNIT) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSES_PER_UNIT - 1);
  localparam logic [TW-1:0] TMR_LOAD   = TW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [PW-1:0]   pulse_cnt;
  logic [TW-1:0]   tmr;
  logic            flow_edge;
  logic            unit_edge;
  logic            last_unit;

  flow_edge_detector u_edge (
    .clock      (clock),
    .reset      (reset),
    .flow_pulse (vif.flow_pulse),
    .flow_edge  (flow_edge)
  );

  assign unit_edge = flow_edge && (pulse_cnt == PULSE_LAST);
  assign last_unit = unit_edge && (vif.remaining == AMOUNT_WIDTH'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      pulse_cnt      <= '0;
      tmr            <= '0;
      vif.valve_open <= 1'b0;
      vif.busy       <= 1'b0;
      vif.done       <= 1'b0;
      vif.aborted    <= 1'b0;
      vif.fault      <= 1'b0;
      vif.dispensed  <= '0;
      vif.remaining  <= '0;
    end else begin
      vif.done    <= 1'b0;
      vif.aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (vif.start) begin
            vif.dispensed <= '0;
            if (vif.amount != '0) begin
              vif.remaining  <= vif.amount;
              vif.valve_open <= 1'b1;
              vif.busy       <= 1'b1;
              pulse_cnt      <= '0;
              tmr            <= TMR_LOAD;
              state          <= ST_DISPENSE;
            end else begin
              vif.remaining <= '0;
              vif.done      <= 1'b1;
            end
          end
        end

        ST_DISPENSE: begin
          // The edge is always counted; abort only decides which pulse reports the exit.
          if (flow_edge) begin
            tmr       <= TMR_LOAD;
            pulse_cnt <= unit_edge ? '0 : pulse_cnt + 1'b1;
            if (unit_edge) begin
              vif.dispensed <= vif.dispensed + 1'b1;
              vif.remaining <= vif.remaining - 1'b1;
            end
          end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end

          if (vif.abort) begin
            vif.aborted    <= 1'b1;
            vif.valve_open <= 1'b0;
            vif.busy       <= 1'b0;
            pulse_cnt      <= '0;
            state          <= ST_IDLE;
          end else if (last_unit) begin
            vif.done       <= 1'b1;
            vif.valve_open <= 1'b0;
            vif.busy       <= 1'b0;
            state          <= ST_IDLE;
          end else if (!flow_edge && tmr == '0) begin
            vif.fault      <= 1'b1;
            vif.valve_open <= 1'b0;
            vif.busy       <= 1'b0;
            state          <= ST_FAULT;
          end
        end

        ST_FAULT: begin
          if (vif.abort) begin
            vif.fault <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_water_valve_controller.sv
// Self-checking bench: directed test-plan scenarios plus random traffic against a unit-count model.
module tb_water_valve_controller;

  localparam int PPU     = 4;
  localparam int TIMEOUT = 20;
  localparam int M_IDLE = 0, M_DISP = 1, M_FAULT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  water_valve_controller_if #(.AMOUNT_WIDTH(32)) bus ();

  water_valve_controller #(
    .AMOUNT_WIDTH    (32),
    .PULSES_PER_UNIT (PPU),
    .TIMEOUT_CYCLES  (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .vif   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: units delivered = total edges since start / PPU.
  int m_mode, m_req, m_edges, m_quiet;
  bit m_prev, m_valve, m_busy, m_done, m_aborted, m_fault;
  int m_disp, m_rem;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      if (tests_failed <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_req = 0; m_edges = 0; m_quiet = 0; m_prev = 0;
    m_valve = 0; m_busy = 0; m_done = 0; m_aborted = 0; m_fault = 0;
    m_disp = 0; m_rem = 0;
  endtask

  task automatic model_step(input bit st, input int amt, input bit ab, input bit fl);
    bit edge_seen;
    edge_seen = fl && !m_prev;
    m_prev = fl;
    m_done = 0;
    m_aborted = 0;
    case (m_mode)
      M_IDLE: if (st) begin
        m_disp = 0;
        if (amt == 0) begin
          m_rem = 0; m_done = 1;
        end else begin
          m_mode = M_DISP; m_req = amt; m_edges = 0; m_quiet = 0;
          m_rem = amt; m_valve = 1; m_busy = 1;
        end
      end
      M_DISP: begin
        if (edge_seen) begin m_edges++; m_quiet = 0; end
        else m_quiet++;
        m_disp = m_edges / PPU;
        m_rem  = m_req - m_disp;
        if (ab) begin
          m_aborted = 1; m_valve = 0; m_busy = 0; m_mode = M_IDLE;
        end else if (m_disp == m_req) begin
          m_done = 1; m_valve = 0; m_busy = 0; m_mode = M_IDLE;
        end else if (m_quiet == TIMEOUT) begin
          m_fault = 1; m_valve = 0; m_busy = 0; m_mode = M_FAULT;
        end
      end
      default: if (ab) begin
        m_fault = 0; m_mode = M_IDLE;
      end
    endcase
  endtask

  task automatic check_outputs();
    check_eq("valve_open", bus.valve_open, m_valve);
    check_eq("busy", bus.busy, m_busy);
    check_eq("done", bus.done, m_done);
    check_eq("aborted", bus.aborted, m_aborted);
    check_eq("fault", bus.fault, m_fault);
    check_eq("dispensed", bus.dispensed, m_disp);
    check_eq("remaining", bus.remaining, m_rem);
  endtask

  task automatic cycle(input bit st, input int amt, input bit ab, input bit fl);
    @(negedge clock);
    check_outputs();
    bus.start = st; bus.amount = amt; bus.abort = ab; bus.flow_pulse = fl;
    @(posedge clock);
    model_step(st, amt, ab, fl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  int rate;

  initial begin
    bus.start = 0; bus.amount = 0; bus.abort = 0; bus.flow_pulse = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 check_outputs();
    @(negedge clock) reset = 0;
    idle(2);

    // 1: three units at 2-high/2-low flow
    cycle(1, 3, 0, 0);
    #1 check_eq("t1_valve_after_start", bus.valve_open, 1);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, 1);
      if (i == 11) begin
        #1 check_eq("t1_done_12th", bus.done, 1);
        check_eq("t1_valve_closed", bus.valve_open, 0);
        check_eq("t1_dispensed", bus.dispensed, 3);
      end
      cycle(0, 0, 0, 1);
      idle(2);
    end
    idle(2);

    // 2: zero amount
    cycle(1, 0, 0, 0);
    #1 check_eq("t2_done", bus.done, 1);
    check_eq("t2_valve", bus.valve_open, 0);
    idle(3);

    // 3: abort after 9 edges, then a fresh start
    cycle(1, 5, 0, 0);
    for (int i = 0; i < 9; i++) begin cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); end
    cycle(0, 0, 1, 0);
    #1 check_eq("t3_aborted", bus.aborted, 1);
    check_eq("t3_dispensed", bus.dispensed, 2);
    check_eq("t3_remaining", bus.remaining, 3);
    idle(2);
    cycle(1, 1, 0, 0);
    #1 check_eq("t3_restart_busy", bus.busy, 1);
    for (int i = 0; i < 4; i++) begin cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); end
    idle(2);

    // 4: timeout fault, start ignored, abort clears
    cycle(1, 2, 0, 0);
    for (int i = 0; i < 4; i++) begin cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); end
    idle(TIMEOUT);
    #1 check_eq("t4_fault", bus.fault, 1);
    check_eq("t4_dispensed", bus.dispensed, 1);
    cycle(1, 1, 0, 0);
    #1 check_eq("t4_start_ignored", bus.valve_open, 0);
    cycle(0, 0, 1, 0);
    #1 check_eq("t4_fault_cleared", bus.fault, 0);
    check_eq("t4_no_aborted", bus.aborted, 0);
    idle(2);

    // 5: abort coincides with the completing edge
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); end
    cycle(0, 0, 1, 1);
    #1 check_eq("t5_aborted", bus.aborted, 1);
    check_eq("t5_no_done", bus.done, 0);
    check_eq("t5_dispensed", bus.dispensed, 1);
    check_eq("t5_remaining", bus.remaining, 0);
    idle(2);

    // 6: asynchronous reset between clock edges
    cycle(1, 3, 0, 0);
    for (int i = 0; i < 4; i++) begin cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); end
    #2 reset = 1;
    #1 check_eq("t6_valve", bus.valve_open, 0);
    check_eq("t6_busy", bus.busy, 0);
    check_eq("t6_dispensed", bus.dispensed, 0);
    check_eq("t6_remaining", bus.remaining, 0);
    bus.flow_pulse = 0;
    model_reset();
    @(negedge clock) reset = 0;
    idle(2);

    // Random traffic
    rate = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 60 == 0) rate = $urandom_range(0, 3);
      cycle(($urandom_range(0, 9) == 0), $urandom_range(0, 4),
            ($urandom_range(0, 59) == 0),
            (rate == 0) ? 1'b0 : ($urandom_range(0, rate) == 0) ^ bus.flow_pulse);
    end
    @(negedge clock);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/water_valve_controller.md
Name: water_valve_controller

Overview:
Delivery end of the water dispenser. Takes the confirmed amount from the entry/accumulator logic on a start strobe and opens the valve. It counts flow-meter pulses until that many units have been delivered, then closes the valve. It also handles user abort and a no-flow timeout fault.

Parameters:
AMOUNT_WIDTH, 32, width of amount and unit counters (matches integer total_amount)
PULSES_PER_UNIT, 10, flow-meter rising edges per dispensed unit (>=1)
TIMEOUT_CYCLES, 1000, clock cycles without a flow edge while dispensing before fault (>=2)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
amount  input  AMOUNT_WIDTH  requested units, sampled only on accepted start
start  input  1  request strobe; accepted only in IDLE
abort  input  1  cancel dispensing, or acknowledge fault
flow_pulse  input  1  flow-meter pulse level
valve_open  output  1  valve drive, 1 = open
busy  output  1  high in DISPENSE
done  output  1  one-cycle pulse on successful completion
aborted  output  1  one-cycle pulse when a dispense is cancelled
fault  output  1  high while in FAULT
dispensed  output  AMOUNT_WIDTH  units delivered in current/last request
remaining  output  AMOUNT_WIDTH  units still to deliver

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0. Pulse counter, timeout counter and edge-detect history cleared.
- States: IDLE, DISPENSE, FAULT. All outputs are registered.
- IDLE, start=1, amount>0:
  - Next edge: remaining<=amount, dispensed<=0, state<=DISPENSE.
  - valve_open=1 and busy=1 from that cycle (1-cycle latency).
- IDLE, start=1, amount==0: done pulses next cycle. Valve stays closed, dispensed<=0, remaining<=0.
- start in DISPENSE or FAULT: ignored.
- Flow edge = flow_pulse 1 this cycle, 0 previous cycle. Edges are counted only in DISPENSE.
- Each edge increments the pulse counter. When the counter reaches PULSES_PER_UNIT it wraps to 0, dispensed+=1 and remaining-=1.
- Completion: the edge that makes remaining go 1->0 does all of the following on the same clock edge:
  - valve_open<=0, busy<=0
  - done pulses for exactly 1 cycle
  - state<=IDLE
- Abort in DISPENSE:
  - Next edge: valve closed, aborted pulses, state<=IDLE.
  - dispensed/remaining hold their current values.
  - Partial pulse count is discarded.
- Abort and a completing edge in the same cycle: abort wins. aborted pulses, done does not. The unit is still counted (dispensed+1, remaining 0).
- Timeout:
  - Counter reloads on entry to DISPENSE and on every flow edge; decrements otherwise.
  - If TIMEOUT_CYCLES cycles pass with no edge: valve_open<=0, busy<=0, fault<=1, state<=FAULT.
- FAULT: held until abort=1. Abort clears fault on the next edge, returns to IDLE, and does not pulse aborted.
- Counters never wrap: remaining never goes below 0; dispensed <= amount.
- Reset mid-dispense closes the valve immediately (asynchronous).

Optional Feature:
FLOW_SYNC_EN
- Defined: flow_pulse passes through a 2-flop synchronizer before edge detection. Edge-to-count latency becomes 3 cycles.
- Undefined: flow_pulse is treated as synchronous to clock. Edge-to-count latency is 1 cycle.
- Timeout, abort and start behaviour are identical in both builds.

Decomposition:
- Shared package water_dispenser_pkg holds:
  - the state enum (IDLE, DISPENSE, FAULT)
  - AMOUNT_WIDTH default (32) and SWITCH_COUNT (10), shared with the entry block
- Natural sub-module: flow_edge_detector.
  - Contains the optional synchronizer plus the rising-edge flop.
  - Outputs a one-cycle flow_edge.
  - The controller FSM and counters stay in the top module.

Test Plan (PULSES_PER_UNIT=4, TIMEOUT_CYCLES=20, FLOW_SYNC_EN undefined):
1. amount=3, start 1 cycle, 12 flow pulses each 2 cycles high / 2 low -> valve_open high 1 cycle after start; dispensed steps 1,2,3 every 4th edge; remaining 3->0; done one pulse on the 12th edge; valve closes the same edge.
2. amount=0, start -> done one pulse next cycle; valve_open never asserts; busy stays 0.
3. amount=5, 9 pulses then abort -> dispensed=2, remaining=3, aborted one pulse, valve closed next edge, done never asserts; a new start with amount=1 is accepted afterwards.
4. amount=2, 4 pulses then no flow for 20 cycles -> dispensed=1, fault=1, valve closed; start ignored while fault; abort clears fault, returns to IDLE, no aborted pulse.
5. amount=1; on the 4th edge, abort is high in the same cycle -> aborted pulses, done does not, dispensed=1, remaining=0.
6. Reset asserted asynchronously mid-dispense (between clock edges) -> valve_open, busy, dispensed and remaining drop to 0 immediately, before the next clock edge.
